// File: rtl/slot_allocator_if.sv
`default_nettype none
// ============================================================================
// Module   : slot_allocator_if
// Purpose  : Offer/grant handshake, release ports and status for slot_allocator.
// Revision : 1.0 - initial release
// ============================================================================
interface slot_allocator_if #(
    parameter int NUM_ENTRIES    = 8,
    parameter int NUM_FREE_PORTS = 2
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic                              alloc_valid;
    logic [IDX_W-1:0]                  alloc_index;
    logic                              alloc_ready;
    logic [NUM_FREE_PORTS-1:0]         free_valid;
    logic [NUM_FREE_PORTS*IDX_W-1:0]   free_index;
    logic [CNT_W-1:0]                  free_count;
    logic [NUM_ENTRIES-1:0]            free_bitmap;
    logic                              double_free_err;

    modport master (
        output alloc_valid, alloc_index, free_count, free_bitmap, double_free_err,
        input  alloc_ready, free_valid, free_index
    );

    modport slave (
        input  alloc_valid, alloc_index, free_count, free_bitmap, double_free_err,
        output alloc_ready, free_valid, free_index
    );
endinterface
`default_nettype wire

// File: rtl/slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : slot_allocator
// Purpose  : Free/used bitmap owner; offers one slot per cycle, multi-port release.
//            Optional macro SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN enables sticky
//            double-free detection.
// Revision : 1.0 - initial release
// ============================================================================
module slot_allocator #(
    parameter int NUM_ENTRIES    = 8,
    parameter int NUM_FREE_PORTS = 2,
    parameter int RR_MODE        = 0
) (
    input  logic             clk,
    input  logic             rst,
    slot_allocator_if.master bus
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0]    r_free_bitmap;
    logic [CNT_W-1:0]          r_free_count;
    logic                      w_alloc_valid;
    logic [IDX_W-1:0]          w_alloc_index;
    logic                      w_grant;
    logic [IDX_W-1:0]          w_tgt [NUM_FREE_PORTS];
    logic [NUM_FREE_PORTS-1:0] w_double;
    logic [NUM_ENTRIES-1:0]    w_set_mask;
    logic [NUM_ENTRIES-1:0]    w_clr_mask;
    logic [CNT_W-1:0]          w_rel_cnt;

    assign w_alloc_valid = |r_free_bitmap;
    assign w_grant       = w_alloc_valid & bus.alloc_ready;

    generate
        if (RR_MODE == 0) begin : g_prio
            always_comb begin
                w_alloc_index = '0;
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (r_free_bitmap[i]) w_alloc_index = IDX_W'(i);
                end
            end
        end else begin : g_rr
            logic [IDX_W-1:0] r_rr_ptr;
            logic [IDX_W:0]   w_pos;

            // Scan downward in distance so the slot nearest rr_ptr is written last.
            always_comb begin
                w_alloc_index = '0;
                w_pos         = '0;
                for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
                    w_pos = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
                    if (w_pos >= (IDX_W+1)'(NUM_ENTRIES)) w_pos = w_pos - (IDX_W+1)'(NUM_ENTRIES);
                    if (r_free_bitmap[w_pos[IDX_W-1:0]]) w_alloc_index = w_pos[IDX_W-1:0];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rr_ptr <= '0;
                end else if (w_grant) begin
                    r_rr_ptr <= (w_alloc_index == IDX_W'(NUM_ENTRIES - 1)) ? '0
                                                                          : w_alloc_index + IDX_W'(1);
                end
            end
        end
    endgenerate

    generate
        for (genvar p = 0; p < NUM_FREE_PORTS; p++) begin : g_tgt
            assign w_tgt[p] = bus.free_index[p*IDX_W +: IDX_W];
        end
    endgenerate

    // A release is illegal if out of range, already free, colliding with the
    // grant, or duplicating a lower-numbered port's target.
    always_comb begin
        w_double   = '0;
        w_set_mask = '0;
        w_rel_cnt  = '0;
        for (int p = 0; p < NUM_FREE_PORTS; p++) begin
            if (bus.free_valid[p]) begin
                if (({1'b0, w_tgt[p]} >= (IDX_W+1)'(NUM_ENTRIES)) ||
                    r_free_bitmap[w_tgt[p]] ||
                    (w_grant && (w_tgt[p] == w_alloc_index))) begin
                    w_double[p] = 1'b1;
                end
                for (int q = 0; q < p; q++) begin
                    if (bus.free_valid[q] && (w_tgt[q] == w_tgt[p])) w_double[p] = 1'b1;
                end
                if (!w_double[p]) begin
                    w_set_mask[w_tgt[p]] = 1'b1;
                    w_rel_cnt            = w_rel_cnt + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_clr_mask = '0;
        if (w_grant) w_clr_mask[w_alloc_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_free_bitmap <= '1;
            r_free_count  <= CNT_W'(NUM_ENTRIES);
        end else begin
            r_free_bitmap <= (r_free_bitmap & ~w_clr_mask) | w_set_mask;
            r_free_count  <= r_free_count - CNT_W'(w_grant) + w_rel_cnt;
        end
    end

`ifdef SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_double) begin
            r_err <= 1'b1;
        end
    end

    assign bus.double_free_err = r_err;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NUM_FREE_PORTS; p++) begin
                if (w_double[p]) $error("slot_allocator: double free on port %0d index %0d", p, w_tgt[p]);
            end
        end
    end
`endif
`else
    assign bus.double_free_err = 1'b0;
`endif

    assign bus.alloc_valid = w_alloc_valid;
    assign bus.alloc_index = w_alloc_index;
    assign bus.free_count  = r_free_count;
    assign bus.free_bitmap = r_free_bitmap;
endmodule
`default_nettype wire

// File: tb/tb_slot_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_slot_allocator
// Purpose  : Directed plus random stimulus on a priority and a round-robin
//            allocator, checked every cycle against a behavioural slot model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slot_allocator;
    localparam int N  = 8;
    localparam int P  = 2;
    localparam int IW = 3;
`ifdef SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN
    localparam bit c_err_on = 1'b1;
`else
    localparam bit c_err_on = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            ready;
    logic [P-1:0]    fv;
    logic [P*IW-1:0] fi;
    logic            chk_en;
    int              n_checks;
    int              n_errors;

    logic [N-1:0] m_bm  [2];
    int           m_ptr [2];
    bit           m_err [2];

    slot_allocator_if #(.NUM_ENTRIES(N), .NUM_FREE_PORTS(P)) bus0 ();
    slot_allocator_if #(.NUM_ENTRIES(N), .NUM_FREE_PORTS(P)) bus1 ();

    assign bus0.alloc_ready = ready;
    assign bus0.free_valid  = fv;
    assign bus0.free_index  = fi;
    assign bus1.alloc_ready = ready;
    assign bus1.free_valid  = fv;
    assign bus1.free_index  = fi;

    slot_allocator #(.NUM_ENTRIES(N), .NUM_FREE_PORTS(P), .RR_MODE(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    slot_allocator #(.NUM_ENTRIES(N), .NUM_FREE_PORTS(P), .RR_MODE(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // First free slot in policy order, or -1 when nothing is free.
    function automatic int offer(input logic [N-1:0] bm, input int ptr, input int mode);
        for (int k = 0; k < N; k++) begin
            int s;
            s = (mode != 0) ? (ptr + k) % N : N - 1 - k;
            if (bm[s]) return s;
        end
        return -1;
    endfunction

    task automatic model_step(input int d);
        int           o;
        bit           g;
        bit           dbl;
        logic [N-1:0] nb;
        o   = offer(m_bm[d], m_ptr[d], d);
        g   = (o >= 0) && ready;
        nb  = m_bm[d];
        dbl = 1'b0;
        if (g) nb[o] = 1'b0;
        for (int p = 0; p < P; p++) begin
            if (fv[p]) begin
                int t;
                bit bad;
                t   = int'(fi[p*IW +: IW]);
                bad = (t >= N) || m_bm[d][t] || (g && t == o);
                for (int q = 0; q < p; q++)
                    if (fv[q] && int'(fi[q*IW +: IW]) == t) bad = 1'b1;
                if (bad) dbl = 1'b1;
                else     nb[t] = 1'b1;
            end
        end
        m_bm[d] = nb;
        if (g && d == 1) m_ptr[d] = (o + 1) % N;
        if (c_err_on && dbl) m_err[d] = 1'b1;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_bm[d]  = '1;
                m_ptr[d] = 0;
                m_err[d] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic cmp(input int d, input logic av, input logic [IW-1:0] ai,
                       input logic [3:0] fc, input logic [N-1:0] bm, input logic er);
        int o;
        o = offer(m_bm[d], m_ptr[d], d);
        chk($sformatf("d%0d_alloc_valid", d), 32'(av), 32'(o >= 0));
        chk($sformatf("d%0d_alloc_index", d), 32'(ai), (o >= 0) ? o : 0);
        chk($sformatf("d%0d_free_count", d), 32'(fc), $countones(m_bm[d]));
        chk($sformatf("d%0d_free_bitmap", d), 32'(bm), 32'(m_bm[d]));
        chk($sformatf("d%0d_double_free_err", d), 32'(er), 32'(m_err[d]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, bus0.alloc_valid, bus0.alloc_index, bus0.free_count, bus0.free_bitmap, bus0.double_free_err);
            cmp(1, bus1.alloc_valid, bus1.alloc_index, bus1.free_count, bus1.free_bitmap, bus1.double_free_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        chk_en   = 1'b0;
        rst      = 1'b1;
        ready    = 1'b0;
        fv       = '0;
        fi       = '0;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // Reset state, then drain
        chk("reset_valid", 32'(bus0.alloc_valid), 1);
        chk("reset_count", 32'(bus0.free_count), 8);
        chk("reset_idx_prio", 32'(bus0.alloc_index), 7);
        chk("reset_idx_rr", 32'(bus1.alloc_index), 0);
        ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) chk("drain_idx", 32'(bus0.alloc_index), 7 - i);
            step();
        end
        chk("drain_empty_valid", 32'(bus0.alloc_valid), 0);
        chk("drain_empty_count", 32'(bus0.free_count), 0);

        // Concurrent release from empty
        ready = 1'b0;
        fv    = 2'b11;
        fi    = {3'd5, 3'd3};
        step();
        chk("conc_count", 32'(bus0.free_count), 2);
        chk("conc_bitmap", 32'(bus0.free_bitmap), 32'h28);
        chk("conc_idx_prio", 32'(bus0.alloc_index), 5);
        chk("conc_idx_rr", 32'(bus1.alloc_index), 3);

        // Grant plus release with four free
        fi = {3'd6, 3'd0};
        step();
        chk("gr_pre_count", 32'(bus0.free_count), 4);
        chk("gr_pre_idx", 32'(bus0.alloc_index), 6);
        ready = 1'b1;
        fv    = 2'b01;
        fi    = {3'd0, 3'd2};
        step();
        ready = 1'b0;
        fv    = '0;
        chk("gr_count", 32'(bus0.free_count), 4);
        chk("gr_bitmap", 32'(bus0.free_bitmap), 32'h2D);
        chk("gr_idx", 32'(bus0.alloc_index), 5);

        // Round-robin skip and wrap
        do_reset();
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        fv    = 2'b01;
        fi    = {3'd0, 3'd0};
        step();
        fv = '0;
        chk("rr_after_release", 32'(bus1.alloc_index), 2);
        ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            chk("rr_seq", 32'(bus1.alloc_index), i);
            step();
        end
        ready = 1'b0;
        chk("rr_wrap_idx", 32'(bus1.alloc_index), 0);
        chk("rr_wrap_valid", 32'(bus1.alloc_valid), 1);

        // Double free
        do_reset();
        ready = 1'b1;
        repeat (7) step();
        ready = 1'b0;
        chk("df_start_count", 32'(bus0.free_count), 1);
        fv = 2'b01;
        fi = {3'd0, 3'd4};
        step();
        chk("df_legal_count", 32'(bus0.free_count), 2);
        chk("df_no_err_yet", 32'(bus0.double_free_err), 0);
        step();
        chk("df_dup_count", 32'(bus0.free_count), 2);
        chk("df_err_set", 32'(bus0.double_free_err), 32'(c_err_on));
        fv = 2'b11;
        fi = {3'd1, 3'd1};
        step();
        fv = '0;
        chk("df_pair_count", 32'(bus0.free_count), 3);
        chk("df_pair_bitmap", 32'(bus0.free_bitmap), 32'h13);
        step();
        chk("df_err_sticky", 32'(bus0.double_free_err), 32'(c_err_on));

        // Reset during grant and releases
        ready = 1'b1;
        fv    = 2'b11;
        fi    = {3'd2, 3'd3};
        rst   = 1'b1;
        step();
        rst   = 1'b0;
        ready = 1'b0;
        fv    = '0;
        chk("mid_rst_bitmap", 32'(bus0.free_bitmap), 32'hFF);
        chk("mid_rst_count", 32'(bus0.free_count), 8);
        chk("mid_rst_err", 32'(bus0.double_free_err), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            ready = ($urandom_range(0, 2) != 0);
            fv    = P'($urandom_range(0, (1 << P) - 1));
            fi    = (P*IW)'($urandom);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end
        rst   = 1'b0;
        ready = 1'b0;
        fv    = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/slot_allocator.md
# slot_allocator

Stateful free-slot allocator for the packet controller's buffer entries. It owns the free/used bitmap, hands out one free slot index per cycle through a valid/ready handshake, and accepts slot releases on several independent free ports. Selection is either highest-index-first or round-robin. It replaces ad-hoc bitmap plus combinational priority-pick logic in the packet buffer path.

## Interface
Parameters:
- NUM_ENTRIES, 8, number of slots; must be ≥2.
- NUM_FREE_PORTS, 2, number of independent release ports; must be ≥1.
- RR_MODE, 0, selection policy:
  - 0: highest free index wins.
  - 1: round-robin, starting after the last granted index.
- Derived IDX_W = $clog2(NUM_ENTRIES).
- Derived CNT_W = $clog2(NUM_ENTRIES+1).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- alloc_valid  out  1  at least one slot is free.
- alloc_index  out  IDX_W  slot offered this cycle; meaningful only when alloc_valid=1.
- alloc_ready  in  1  consumer takes the offered slot when alloc_valid=1.
- free_valid  in  NUM_FREE_PORTS  per-port release strobe.
- free_index  in  NUM_FREE_PORTS*IDX_W  per-port slot to release; port p occupies bits [p*IDX_W +: IDX_W].
- free_count  out  CNT_W  number of free slots (registered).
- free_bitmap  out  NUM_ENTRIES  registered free map; 1 = free.
- double_free_err  out  1  sticky error flag; see Configuration.

## Operation
- **State:** free_bitmap, free_count, rr_ptr (IDX_W bits), and err_q.
- **Reset values:**
  - free_bitmap = all ones
  - free_count = NUM_ENTRIES
  - rr_ptr = 0
  - double_free_err = 0
  - Therefore alloc_valid = 1 after reset. alloc_index = NUM_ENTRIES-1 when RR_MODE=0, and 0 when RR_MODE=1.
- **Offer:** alloc_valid and alloc_index are combinational from registered state only. They never depend on alloc_ready or on the free ports.
  - RR_MODE=0: alloc_index is the highest set bit of free_bitmap.
  - RR_MODE=1: alloc_index is the first set bit scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_ENTRIES.
  - When no slot is free, alloc_valid=0 and alloc_index=0.
- **Grant:** when alloc_valid && alloc_ready, the bit at alloc_index is cleared next cycle.
  - In RR_MODE=1, rr_ptr <= (alloc_index+1) mod NUM_ENTRIES, wrapping to 0 when the index is NUM_ENTRIES-1.
  - rr_ptr is unchanged when there is no grant.
- **Release:** each port p with free_valid[p]=1 sets bit free_index[p] next cycle.
  - A release is legal only when the target bit is currently 0 and it is not also the slot granted this cycle.
  - **Double free:** the target is already free, or equals another lower-numbered port's target in the same cycle. It is ignored for count purposes and the bit stays 1.
  - free_index values ≥ NUM_ENTRIES, possible when NUM_ENTRIES is not a power of 2, are also ignored and count as double free.
- **Count update:** free_count_next = free_count − grant + (number of legal releases). The result is always within 0..NUM_ENTRIES.
- **Same-cycle grant and release:**
  - Both apply.
  - A slot released in cycle N is first offerable in cycle N+1; there is no bypass.
  - A release targeting the slot being granted in that same cycle is a double free: the grant wins and the bit ends at 0.

## Timing
- Grant-to-bitmap latency: 1 cycle. Release-to-offer latency: 1 cycle.
- Back-to-back grants every cycle are supported while alloc_valid=1.
- **Empty (free_count=0):**
  - alloc_valid=0; alloc_ready is ignored.
  - A release in cycle N gives alloc_valid=1 in cycle N+1.
- **Full (all free):** all releases are double frees.
- **rst mid-operation:** state returns to reset values on the next edge regardless of concurrent grant or release. Inputs sampled in that cycle are discarded.

## Configuration
- Macro: SLOT_ALLOCATOR_DOUBLE_FREE_CHECK_EN.
- **Defined:**
  - double_free_err is set on the cycle after any double-free condition.
  - It stays 1 until rst.
  - Simulation builds also fire an $error naming the port and index.
- **Undefined:**
  - Detection logic is compiled out and double_free_err is tied 0.
  - Illegal releases still leave the bitmap bit set. free_count still counts only legal releases, so the bitmap and count stay consistent.

## Test plan
- **Reset, drain:** reset, NUM_ENTRIES=8, RR_MODE=0, alloc_ready=1 for 9 cycles → indices 7,6,5,4,3,2,1,0 are granted; free_count steps down to 0; alloc_valid=0 on cycle 9.
- **Round-robin:** RR_MODE=1, grant 0 and 1, release slot 0 → next offer is 2, not 0. Keep granting through 7 → the next offer wraps to 0.
- **Concurrent release:** from empty, ports 0 and 1 release 3 and 5 in the same cycle → next cycle free_count=2, bitmap=8'b0010_1000, alloc_index=5 (RR_MODE=0).
- **Grant plus release:** with free_count=4, grant slot 6 while releasing slot 2 in the same cycle → free_count stays 4; slot 2 is offered no earlier than the next cycle.
- **Double free (macro on):** release already-free slot 4, then ports 0 and 1 both release slot 1 in one cycle → double_free_err=1 from the next cycle and sticky; free_count rises by 1 only for slot 1.
- **Mid-operation reset:** assert rst during a cycle with a grant and two releases → next cycle the bitmap is all ones, free_count=8, double_free_err=0.
